// File: rtl/axi4lite_pkg.sv
// ----------------------------------------------------------------------------
// axi4lite_pkg
// Shared types and default sizes for the AXI4-Lite register-memory slave.
//   resp_t      : AXI response encoding
//   rd_state_t  : read channel FSM states
//   wr_state_t  : write channel FSM states
//   range_resp  : maps an address range hit to OKAY / SLVERR
// ----------------------------------------------------------------------------
package axi4lite_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    function automatic resp_t range_resp(input logic in_range);
        resp_t resp;
        if (in_range) begin
            resp = RESP_OKAY;
        end else begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// ----------------------------------------------------------------------------
// axi4lite_regfile
// MEM_DEPTH x DATA_WIDTH word storage.
//   i_clk    : clock
//   i_srst   : synchronous clear of every word and of the read register
//   i_we     : write enable, i_waddr word index, i_wdata / i_wstrb byte lanes
//   i_re     : read enable, i_raddr word index
//   i_rhit   : read address is in range; when low the read register loads 0
//   o_rdata  : registered read data, held between read enables
// ----------------------------------------------------------------------------
import axi4lite_pkg::*;

module axi4lite_regfile #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    localparam int IDX_W     = $clog2(MEM_DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_raddr,
    input  logic                  i_rhit,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array: clear on reset, otherwise byte-lane masked write.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register: samples the array before any same-edge write lands.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rhit ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_slave.sv
// ----------------------------------------------------------------------------
// axi4_lite_slave
// AXI4-Lite slave backed by a word-addressable register memory.
//   A_CLK / A_RSTn            : clock, synchronous active-high reset
//   AW_* / W_* / B_*          : write address, data and response channels
//   AR_* / R_*                : read address and data channels
// Word index is ADDR[IDX_W+1:2]; addresses at or beyond MEM_DEPTH*4 answer
// SLVERR, leave memory untouched and read as zero.
// ----------------------------------------------------------------------------
import axi4lite_pkg::*;

module axi4_lite_slave #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    localparam int IDX_W     = $clog2(MEM_DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  A_CLK,
    input  logic                  A_RSTn,
    input  logic                  AW_VALID,
    output logic                  AW_READY,
    input  logic [ADDR_WIDTH-1:0] AW_ADDR,
    input  logic [2:0]            AW_PROT,
    input  logic                  W_VALID,
    output logic                  W_READY,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    input  logic [STRB_W-1:0]     W_STRB,
    output logic                  B_VALID,
    input  logic                  B_READY,
    output logic [1:0]            B_RESP,
    input  logic                  AR_VALID,
    output logic                  AR_READY,
    input  logic [ADDR_WIDTH-1:0] AR_ADDR,
    input  logic [2:0]            AR_PROT,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic [1:0]            R_RESP
);

    // ---------------- write channel ----------------
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_state_nxt;
    logic                  r_aw_ready;
    logic                  r_w_ready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  r_b_valid;
    resp_t                 r_b_resp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_have_aw;
    logic                  w_have_w;
    logic                  w_commit;
    logic                  w_wr_ok;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_nxt;
    logic                  r_ar_ready;
    logic                  r_r_valid;
    resp_t                 r_r_resp;
    logic                  w_ar_hs;
    logic                  w_rd_ok;
    logic                  w_unused;

    assign w_aw_hs   = AW_VALID & r_aw_ready;
    assign w_w_hs    = W_VALID & r_w_ready;
    assign w_have_aw = r_aw_done | w_aw_hs;
    assign w_have_w  = r_w_done | w_w_hs;
    assign w_commit  = (r_wr_state == WR_IDLE) & w_have_aw & w_have_w;

    // A beat captured earlier takes priority; its READY is already low so
    // no new beat of that channel can arrive in the same cycle.
    assign w_wr_addr = r_aw_done ? r_aw_addr : AW_ADDR;
    assign w_wr_data = r_w_done  ? r_w_data  : W_DATA;
    assign w_wr_strb = r_w_done  ? r_w_strb  : W_STRB;
    assign w_wr_ok   = (w_wr_addr >> (IDX_W + 2)) == '0;

    assign w_ar_hs   = AR_VALID & r_ar_ready;
    assign w_rd_ok   = (AR_ADDR >> (IDX_W + 2)) == '0;

    assign w_unused  = ^{AW_PROT, AR_PROT};

    // Write FSM next-state decode.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_commit) begin
                    w_wr_state_nxt = WR_RESP;
                end else begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (B_READY) begin
                    w_wr_state_nxt = WR_IDLE;
                end else begin
                    w_wr_state_nxt = WR_RESP;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge A_CLK) begin
        if (A_RSTn) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Write channel handshake flags, beat capture and response register.
    always_ff @(posedge A_CLK) begin
        if (A_RSTn) begin
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_commit) begin
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_b_valid  <= 1'b1;
                        r_b_resp   <= range_resp(w_wr_ok);
                    end else begin
                        r_aw_ready <= ~w_have_aw;
                        r_w_ready  <= ~w_have_w;
                        r_aw_done  <= w_have_aw;
                        r_w_done   <= w_have_w;
                        if (w_aw_hs) begin
                            r_aw_addr <= AW_ADDR;
                        end
                        if (w_w_hs) begin
                            r_w_data <= W_DATA;
                            r_w_strb <= W_STRB;
                        end
                    end
                end
                WR_RESP: begin
                    if (B_READY) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_b_valid <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_DATA;
                end else begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (R_READY) begin
                    w_rd_state_nxt = RD_IDLE;
                end else begin
                    w_rd_state_nxt = RD_DATA;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge A_CLK) begin
        if (A_RSTn) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Read channel ready/valid and response register.
    always_ff @(posedge A_CLK) begin
        if (A_RSTn) begin
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_resp   <= range_resp(w_rd_ok);
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (R_READY) begin
                        r_r_valid  <= 1'b0;
                        r_ar_ready <= 1'b1;
                    end
                end
                default: begin
                    r_r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Read data is loaded only on an AR handshake, so it stays stable while
    // R_VALID waits for R_READY.
    axi4lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_regfile (
        .i_clk   (A_CLK),
        .i_srst  (A_RSTn),
        .i_we    (w_commit & w_wr_ok),
        .i_waddr (w_wr_addr[IDX_W+1:2]),
        .i_wdata (w_wr_data),
        .i_wstrb (w_wr_strb),
        .i_re    (w_ar_hs),
        .i_raddr (AR_ADDR[IDX_W+1:2]),
        .i_rhit  (w_rd_ok),
        .o_rdata (R_DATA)
    );

    assign AW_READY = r_aw_ready;
    assign W_READY  = r_w_ready;
    assign B_VALID  = r_b_valid;
    assign B_RESP   = r_b_resp;
    assign AR_READY = r_ar_ready;
    assign R_VALID  = r_r_valid;
    assign R_RESP   = r_r_resp;

endmodule

// File: tb/tb_axi4_lite_slave.sv
module tb_axi4_lite_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [31:0] AW_ADDR, AR_ADDR, W_DATA, R_DATA;
    logic [3:0]  W_STRB;
    logic [2:0]  AW_PROT, AR_PROT;
    logic [1:0]  B_RESP, R_RESP;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_lite_slave dut (
        .A_CLK    (clk),
        .A_RSTn   (rst),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .AW_ADDR  (AW_ADDR),
        .AW_PROT  (AW_PROT),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .W_DATA   (W_DATA),
        .W_STRB   (W_STRB),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_RESP   (B_RESP),
        .AR_VALID (AR_VALID),
        .AR_READY (AR_READY),
        .AR_ADDR  (AR_ADDR),
        .AR_PROT  (AR_PROT),
        .R_VALID  (R_VALID),
        .R_READY  (R_READY),
        .R_DATA   (R_DATA),
        .R_RESP   (R_RESP)
    );

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic aw_s, w_s;
        int   n;
        AW_ADDR = addr; W_DATA = data; W_STRB = strb;
        AW_VALID = 1'b1; W_VALID = 1'b1;
        n = 0;
        while ((AW_VALID || W_VALID) && n < 20) begin
            aw_s = AW_READY; w_s = W_READY;
            tick();
            if (aw_s) AW_VALID = 1'b0;
            if (w_s)  W_VALID  = 1'b0;
            n++;
        end
        AW_VALID = 1'b0; W_VALID = 1'b0;
        n = 0;
        while (!B_VALID && n < 20) begin
            tick();
            n++;
        end
        if (!B_VALID) timeout_fail(name);
        resp = B_RESP;
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        AR_ADDR = addr; AR_VALID = 1'b1;
        n = 0;
        while (!AR_READY && n < 20) begin
            tick();
            n++;
        end
        tick();
        AR_VALID = 1'b0;
        n = 0;
        while (!R_VALID && n < 20) begin
            tick();
            n++;
        end
        if (!R_VALID) timeout_fail(name);
        data = R_DATA;
        resp = R_RESP;
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;

        //                 wr    addr          data          strb   exp_data      exp_resp
        vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0000_0001, 4'hF, 32'h0,         2'b00};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
        vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0000_0000, 2'b10};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
        vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
        vecs[11] = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
        vecs[12] = '{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0001, 2'b00};

        rst = 1'b1;
        AW_VALID = 1'b0; W_VALID = 1'b0; B_READY = 1'b0; AR_VALID = 1'b0; R_READY = 1'b0;
        AW_ADDR = 32'h0; AR_ADDR = 32'h0; W_DATA = 32'h0; W_STRB = 4'h0;
        AW_PROT = 3'b000; AR_PROT = 3'b000;

        // Reset state
        repeat (3) tick();
        check("rst_aw_ready", {31'h0, AW_READY}, 32'h0);
        check("rst_ar_ready", {31'h0, AR_READY}, 32'h0);
        check("rst_b_valid",  {31'h0, B_VALID},  32'h0);
        check("rst_r_valid",  {31'h0, R_VALID},  32'h0);
        check("rst_r_data",   R_DATA,            32'h0);
        check("rst_resps",    {28'h0, B_RESP, R_RESP}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_readys", {29'h0, AW_READY, W_READY, AR_READY}, 32'h7);

        // Table-driven transactions
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                do_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), {30'h0, rs}, {30'h0, vecs[i].exp_resp});
            end else begin
                do_read($sformatf("vec%0d_rd", i), vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'h0, rs}, {30'h0, vecs[i].exp_resp});
            end
        end

        // W beat two cycles ahead of AW beat
        W_DATA = 32'hDEAD_BEEF; W_STRB = 4'hF; W_VALID = 1'b1;
        tick();
        W_VALID = 1'b0;
        check("early_w_ready_low", {31'h0, W_READY}, 32'h0);
        check("early_aw_ready_hi", {31'h0, AW_READY}, 32'h1);
        check("early_no_b_1", {31'h0, B_VALID}, 32'h0);
        tick();
        check("early_no_b_2", {31'h0, B_VALID}, 32'h0);
        AW_ADDR = 32'h0000_0008; AW_VALID = 1'b1;
        tick();
        AW_VALID = 1'b0;
        check("early_b_valid", {31'h0, B_VALID}, 32'h1);
        check("early_b_resp", {30'h0, B_RESP}, 32'h0);
        tick();
        check("early_b_hold", {31'h0, B_VALID}, 32'h1);
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
        check("early_b_done", {31'h0, B_VALID}, 32'h0);
        check("early_readys_back", {30'h0, AW_READY, W_READY}, 32'h3);
        tick();
        check("early_single_b", {31'h0, B_VALID}, 32'h0);
        do_read("early_rd", 32'h0000_0008, rd, rs);
        check("early_rdata", rd, 32'hDEAD_BEEF);

        // Same-cycle read and write of one word returns the old contents
        AR_ADDR = 32'h0000_0004; AR_VALID = 1'b1;
        AW_ADDR = 32'h0000_0004; AW_VALID = 1'b1;
        W_DATA = 32'h0000_0055; W_STRB = 4'hF; W_VALID = 1'b1;
        tick();
        AR_VALID = 1'b0; AW_VALID = 1'b0; W_VALID = 1'b0;
        check("rw_r_valid", {31'h0, R_VALID}, 32'h1);
        check("rw_b_valid", {31'h0, B_VALID}, 32'h1);
        check("rw_old_data", R_DATA, 32'h0000_0001);
        R_READY = 1'b1; B_READY = 1'b1;
        tick();
        R_READY = 1'b0; B_READY = 1'b0;
        do_read("rw_rd", 32'h0000_0004, rd, rs);
        check("rw_new_data", rd, 32'h0000_0055);

        // Stalled read response, then reset mid-wait
        AR_ADDR = 32'h0000_0008; AR_VALID = 1'b1;
        tick();
        AR_VALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_r_valid", c), {31'h0, R_VALID}, 32'h1);
            check($sformatf("stall%0d_r_data", c), R_DATA, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_ar_ready", c), {31'h0, AR_READY}, 32'h0);
            tick();
        end
        rst = 1'b1;
        tick();
        check("midrst_r_valid", {31'h0, R_VALID}, 32'h0);
        check("midrst_r_data", R_DATA, 32'h0);
        check("midrst_ar_ready", {31'h0, AR_READY}, 32'h0);
        rst = 1'b0;
        tick();
        do_read("midrst_rd8", 32'h0000_0008, rd, rs);
        check("midrst_mem8", rd, 32'h0);
        do_read("midrst_rd4", 32'h0000_0004, rd, rs);
        check("midrst_mem4", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
